// File: rtl/icache_nway_cwf.sv
// N-way set-associative instruction cache, multiword lines, critical-word-first refill with early restart.
// Latency: hit returns data 1 cycle after cpu_req; miss returns 1 cycle after the first refill beat.
// Backpressure: cpu_stall is high while a miss/refill/flush is in progress; mem_req is held until mem_ready.
module icache_nway_cwf #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int CACHE_SIZE    = 1024,
  parameter int ASSOCIATIVITY = 4,
  parameter int BLOCK_SIZE    = 4,
  parameter int REPL_POLICY   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic [DATA_WIDTH-1:0] cpu_data,
  output logic                  cpu_valid,
  output logic                  cpu_stall,
  input  logic                  flush_req,
  output logic                  flush_busy,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [$clog2(BLOCK_SIZE):0] mem_burst_len,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_ready,
  input  logic                  mem_valid,
  input  logic                  mem_last,
  output logic                  cache_hit,
  output logic                  cache_miss,
  output logic                  cache_evict
);

  localparam int SETS     = CACHE_SIZE / BLOCK_SIZE / ASSOCIATIVITY;
  localparam int OFF      = $clog2(BLOCK_SIZE);
  localparam int LEN_BITS = OFF + 1;
  localparam int SET_BITS = $clog2(SETS);
  localparam int TAG_BITS = ADDR_WIDTH - SET_BITS - OFF - 2;
  localparam int WAYW     = (ASSOCIATIVITY > 1) ? $clog2(ASSOCIATIVITY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL, S_FLUSH} state_t;

  state_t state, state_n;

  // Request address fields
  logic [TAG_BITS-1:0] a_tag;
  logic [SET_BITS-1:0] a_set;
  logic [OFF-1:0]      a_word;

  assign a_word = cpu_addr[OFF+1:2];
  assign a_set  = cpu_addr[OFF+2+SET_BITS-1:OFF+2];
  assign a_tag  = cpu_addr[ADDR_WIDTH-1:OFF+2+SET_BITS];

  // Storage: valid/replacement state is reset, tag/data arrays are not
  logic [ASSOCIATIVITY-1:0] valid    [SETS];
  logic [TAG_BITS-1:0]      tag_mem  [SETS][ASSOCIATIVITY];
  logic [DATA_WIDTH-1:0]    data_mem [SETS][ASSOCIATIVITY][BLOCK_SIZE];
  logic [WAYW-1:0]          rr_ptr   [SETS];
  logic [WAYW-1:0]          age      [SETS][ASSOCIATIVITY];

  // Miss context latched in IDLE and used through REQ/FILL
  logic [TAG_BITS-1:0] f_tag;
  logic [SET_BITS-1:0] f_set;
  logic [OFF-1:0]      f_word;
  logic [WAYW-1:0]     f_way;
  logic                f_evict;
  logic [OFF-1:0]      beat;
  logic [SET_BITS-1:0] fl_set;
  logic                flush_pend;

  logic                flush_go;
  logic                hit;
  logic [WAYW-1:0]     hit_way;
  logic                inv_found;
  logic [WAYW-1:0]     inv_way;
  logic [WAYW-1:0]     lru_way;
  logic [WAYW-1:0]     victim;
  logic [OFF-1:0]      wr_word;
  logic                last_beat;
  logic                touch_en;
  logic [SET_BITS-1:0] touch_set;
  logic [WAYW-1:0]     touch_way;

  assign flush_go  = flush_req || flush_pend;
  assign wr_word   = f_word + beat;
  assign last_beat = (beat == OFF'(BLOCK_SIZE - 1));

  // Tag lookup across all ways of the addressed set
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < ASSOCIATIVITY; w++) begin
      if (valid[a_set][w] && (tag_mem[a_set][w] == a_tag)) begin
        hit     = 1'b1;
        hit_way = WAYW'(w);
      end
    end
  end

  // Victim choice: lowest invalid way first, then round-robin pointer or oldest way
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
      if (!valid[a_set][w]) begin
        inv_found = 1'b1;
        inv_way   = WAYW'(w);
      end
    end
    for (int w = 0; w < ASSOCIATIVITY; w++) begin
      if (age[a_set][w] == WAYW'(ASSOCIATIVITY - 1)) lru_way = WAYW'(w);
    end
    if (inv_found)             victim = inv_way;
    else if (REPL_POLICY == 1) victim = lru_way;
    else                       victim = rr_ptr[a_set];
  end

  // Age refresh on an IDLE hit or on a completed fill
  always_comb begin
    touch_en  = 1'b0;
    touch_set = a_set;
    touch_way = hit_way;
    if (state == S_IDLE && cpu_req && hit && !flush_go) begin
      touch_en = 1'b1;
    end else if (state == S_FILL && mem_valid && last_beat) begin
      touch_en  = 1'b1;
      touch_set = f_set;
      touch_way = f_way;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_n       = state;
    cpu_stall     = 1'b0;
    mem_req       = 1'b0;
    mem_addr      = '0;
    mem_burst_len = '0;
    flush_busy    = 1'b0;
    case (state)
      S_IDLE: begin
        if (flush_go) begin
          // a request colliding with a flush is not served, so hold fetch off
          state_n   = S_FLUSH;
          cpu_stall = cpu_req;
        end else if (cpu_req && !hit) begin
          state_n   = S_REQ;
          cpu_stall = 1'b1;
        end
      end
      S_REQ: begin
        cpu_stall     = 1'b1;
        mem_req       = 1'b1;
        mem_addr      = {f_tag, f_set, f_word, 2'b00};
        mem_burst_len = LEN_BITS'(BLOCK_SIZE - 1);
        if (mem_ready) state_n = S_FILL;
      end
      S_FILL: begin
        cpu_stall = 1'b1;
        if (mem_valid && (last_beat || mem_last)) state_n = S_IDLE;
      end
      S_FLUSH: begin
        cpu_stall  = 1'b1;
        flush_busy = 1'b1;
        if (fl_set == SET_BITS'(SETS - 1)) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Control state, valid bits, replacement state and registered CPU outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid[s]  <= '0;
        rr_ptr[s] <= '0;
        for (int w = 0; w < ASSOCIATIVITY; w++) age[s][w] <= WAYW'(w);
      end
      flush_pend  <= 1'b0;
      f_tag       <= '0;
      f_set       <= '0;
      f_word      <= '0;
      f_way       <= '0;
      f_evict     <= 1'b0;
      beat        <= '0;
      fl_set      <= '0;
      cpu_data    <= '0;
      cpu_valid   <= 1'b0;
      cache_hit   <= 1'b0;
      cache_miss  <= 1'b0;
      cache_evict <= 1'b0;
    end else begin
      cpu_valid   <= 1'b0;
      cache_hit   <= 1'b0;
      cache_miss  <= 1'b0;
      cache_evict <= 1'b0;
      case (state)
        S_IDLE: begin
          if (flush_go) begin
            flush_pend <= 1'b0;
            fl_set     <= '0;
          end else if (cpu_req) begin
            if (hit) begin
              cpu_data  <= data_mem[a_set][hit_way][a_word];
              cpu_valid <= 1'b1;
              cache_hit <= 1'b1;
            end else begin
              f_tag   <= a_tag;
              f_set   <= a_set;
              f_word  <= a_word;
              f_way   <= victim;
              f_evict <= valid[a_set][victim];
            end
          end
        end
        S_REQ: begin
          if (flush_req) flush_pend <= 1'b1;
          if (mem_ready) begin
            // line goes invalid before any beat lands so a partial line never hits
            valid[f_set][f_way] <= 1'b0;
            beat                <= '0;
          end
        end
        S_FILL: begin
          if (flush_req) flush_pend <= 1'b1;
          if (mem_valid) begin
            if (beat == '0) begin
              cpu_data    <= mem_data;
              cpu_valid   <= 1'b1;
              cache_miss  <= 1'b1;
              cache_evict <= f_evict;
            end
            if (last_beat) begin
              valid[f_set][f_way] <= 1'b1;
              rr_ptr[f_set] <= (rr_ptr[f_set] == WAYW'(ASSOCIATIVITY - 1)) ? '0
                                                                            : rr_ptr[f_set] + 1'b1;
            end
            beat <= beat + 1'b1;
          end
        end
        S_FLUSH: begin
          valid[fl_set]  <= '0;
          rr_ptr[fl_set] <= '0;
          for (int w = 0; w < ASSOCIATIVITY; w++) age[fl_set][w] <= WAYW'(w);
          fl_set <= fl_set + 1'b1;
        end
        default: ;
      endcase
      if (touch_en) begin
        for (int w = 0; w < ASSOCIATIVITY; w++) begin
          if (age[touch_set][w] < age[touch_set][touch_way])
            age[touch_set][w] <= age[touch_set][w] + 1'b1;
        end
        age[touch_set][touch_way] <= '0;
      end
    end
  end

  // Tag and data array writes during refill
  always_ff @(posedge clk) begin
    if (!rst && state == S_FILL && mem_valid) begin
      data_mem[f_set][f_way][wr_word] <= mem_data;
      if (last_beat) tag_mem[f_set][f_way] <= f_tag;
    end
  end

endmodule

// File: tb/tb_icache_nway_cwf.sv
// Directed bench for icache_nway_cwf: one round-robin and one LRU instance, driven one at a time.
// Inputs change 1ns after the rising edge; outputs are sampled there or 1ns later for combinational ones.
// Line data is base+word so every expected value is written out by hand below.
module tb_icache_nway_cwf;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        cpu_req   [2];
  logic [31:0] cpu_addr  [2];
  logic [31:0] cpu_data  [2];
  logic        cpu_valid [2];
  logic        cpu_stall [2];
  logic        flush_req [2];
  logic        flush_busy[2];
  logic        mem_req   [2];
  logic [31:0] mem_addr  [2];
  logic [2:0]  mem_burst_len[2];
  logic [31:0] mem_data  [2];
  logic        mem_ready [2];
  logic        mem_valid [2];
  logic        mem_last  [2];
  logic        cache_hit [2];
  logic        cache_miss[2];
  logic        cache_evict[2];

  int n_tests = 0;
  int n_fail  = 0;

  icache_nway_cwf #(.REPL_POLICY(0)) u_rr (
    .clk(clk), .rst(rst[0]), .cpu_req(cpu_req[0]), .cpu_addr(cpu_addr[0]),
    .cpu_data(cpu_data[0]), .cpu_valid(cpu_valid[0]), .cpu_stall(cpu_stall[0]),
    .flush_req(flush_req[0]), .flush_busy(flush_busy[0]), .mem_req(mem_req[0]),
    .mem_addr(mem_addr[0]), .mem_burst_len(mem_burst_len[0]), .mem_data(mem_data[0]),
    .mem_ready(mem_ready[0]), .mem_valid(mem_valid[0]), .mem_last(mem_last[0]),
    .cache_hit(cache_hit[0]), .cache_miss(cache_miss[0]), .cache_evict(cache_evict[0])
  );

  icache_nway_cwf #(.REPL_POLICY(1)) u_lru (
    .clk(clk), .rst(rst[1]), .cpu_req(cpu_req[1]), .cpu_addr(cpu_addr[1]),
    .cpu_data(cpu_data[1]), .cpu_valid(cpu_valid[1]), .cpu_stall(cpu_stall[1]),
    .flush_req(flush_req[1]), .flush_busy(flush_busy[1]), .mem_req(mem_req[1]),
    .mem_addr(mem_addr[1]), .mem_burst_len(mem_burst_len[1]), .mem_data(mem_data[1]),
    .mem_ready(mem_ready[1]), .mem_valid(mem_valid[1]), .mem_last(mem_last[1]),
    .cache_hit(cache_hit[1]), .cache_miss(cache_miss[1]), .cache_evict(cache_evict[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input int d, input string tag);
    check({tag, " ctl"}, {25'd0, cpu_valid[d], cpu_stall[d], flush_busy[d], mem_req[d],
                          cache_hit[d], cache_miss[d], cache_evict[d]}, 32'd0);
    check({tag, " cpu_data"}, cpu_data[d], 32'd0);
    check({tag, " mem_addr"}, mem_addr[d], 32'd0);
    check({tag, " burst_len"}, {29'd0, mem_burst_len[d]}, 32'd0);
  endtask

  task automatic hit_read(input int d, input logic [31:0] addr, input logic [31:0] exp,
                          input string tag);
    cpu_addr[d] = addr;
    cpu_req[d]  = 1'b1;
    #1;
    check({tag, " no stall"}, cpu_stall[d], 1'b0);
    tick;
    cpu_req[d] = 1'b0;
    check({tag, " valid"}, cpu_valid[d], 1'b1);
    check({tag, " data"}, cpu_data[d], exp);
    check({tag, " hit/miss"}, {30'd0, cache_hit[d], cache_miss[d]}, 32'd2);
    tick;
    check({tag, " single pulse"}, {30'd0, cpu_valid[d], cache_hit[d]}, 32'd0);
  endtask

  // Miss, REQ wait, then beats starting at the critical word; optional gap, flush pulse, short burst.
  task automatic miss_fill(input int d, input logic [31:0] addr, input int wait_c,
                           input logic [31:0] base, input int last_beat, input logic exp_evict,
                           input int gap_at, input int flush_at, input string tag);
    int wi;
    wi = int'(addr[3:2]);
    cpu_addr[d] = addr;
    cpu_req[d]  = 1'b1;
    #1;
    check({tag, " miss stall"}, cpu_stall[d], 1'b1);
    tick;
    cpu_req[d] = 1'b0;
    check({tag, " mem_req"}, mem_req[d], 1'b1);
    check({tag, " mem_addr"}, mem_addr[d], {addr[31:2], 2'b00});
    check({tag, " burst_len"}, {29'd0, mem_burst_len[d]}, 32'd3);
    repeat (wait_c) tick;
    check({tag, " req held"}, {31'd0, mem_req[d]}, 32'd1);
    mem_ready[d] = 1'b1;
    tick;
    mem_ready[d] = 1'b0;
    check({tag, " req dropped"}, mem_req[d], 1'b0);
    for (int n = 0; n <= last_beat; n++) begin
      if (n == gap_at) tick;
      mem_valid[d] = 1'b1;
      mem_data[d]  = base + 32'((wi + n) % 4);
      mem_last[d]  = (n == last_beat);
      flush_req[d] = (n == flush_at);
      tick;
      mem_valid[d] = 1'b0;
      mem_last[d]  = 1'b0;
      flush_req[d] = 1'b0;
      if (n == 0) begin
        check({tag, " early valid"}, cpu_valid[d], 1'b1);
        check({tag, " early data"}, cpu_data[d], base + 32'(wi));
        check({tag, " miss/evict"}, {30'd0, cache_miss[d], cache_evict[d]},
              {30'd0, 1'b1, exp_evict});
      end else begin
        check({tag, " no repeat"}, {30'd0, cpu_valid[d], cache_miss[d]}, 32'd0);
      end
    end
    check({tag, " back idle"}, {30'd0, cpu_stall[d], mem_req[d]}, 32'd0);
  endtask

  initial begin
    int fl_cnt;
    int guard;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; cpu_req[d] = 1'b0; cpu_addr[d] = '0; flush_req[d] = 1'b0;
      mem_data[d] = '0; mem_ready[d] = 1'b0; mem_valid[d] = 1'b0; mem_last[d] = 1'b0;
    end
    tick;
    tick;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    tick;
    check_zero(0, "reset rr");
    check_zero(1, "reset lru");

    // Cold miss, critical word 2, ready after two REQ cycles, then hits on the line
    miss_fill(0, 32'h8, 2, 32'hA0, 3, 1'b0, -1, -1, "cold 0x8");
    hit_read(0, 32'h0, 32'hA0, "hit 0x0");
    hit_read(0, 32'hC, 32'hA3, "hit 0xC");

    // Round-robin: fill set 0, pointer wraps back to way 0 (the 0x0000 line)
    miss_fill(0, 32'h1000, 0, 32'hB0, 3, 1'b0, 2, -1, "rr 0x1000");
    miss_fill(0, 32'h2000, 1, 32'hC0, 3, 1'b0, -1, -1, "rr 0x2000");
    miss_fill(0, 32'h3000, 0, 32'hD0, 3, 1'b0, -1, -1, "rr 0x3000");
    hit_read(0, 32'h0, 32'hA0, "rr hit 0x0");
    miss_fill(0, 32'h4000, 0, 32'hE0, 3, 1'b1, -1, -1, "rr 0x4000");
    hit_read(0, 32'h2004, 32'hC1, "rr keep 0x2004");
    miss_fill(0, 32'h0, 0, 32'hA0, 3, 1'b1, -1, -1, "rr re-miss 0x0");
    hit_read(0, 32'h4008, 32'hE2, "rr hit 0x4008");

    // Short burst: mem_last on beat 1 leaves the line invalid
    miss_fill(0, 32'h14, 0, 32'hF0, 1, 1'b0, -1, -1, "short 0x14");
    miss_fill(0, 32'h14, 0, 32'hF0, 3, 1'b0, -1, -1, "after short 0x14");
    hit_read(0, 32'h18, 32'hF2, "hit 0x18");

    // Flush requested mid-fill: fill completes, then exactly 64 busy cycles
    miss_fill(0, 32'h20, 1, 32'h50, 3, 1'b0, -1, 1, "flush fill");
    check("fill before flush", flush_busy[0], 1'b0);
    tick;
    check("flush stall", cpu_stall[0], 1'b1);
    fl_cnt = 0;
    guard  = 0;
    while (flush_busy[0] && guard < 200) begin
      flush_req[0] = (fl_cnt == 10);
      fl_cnt++;
      guard++;
      tick;
    end
    flush_req[0] = 1'b0;
    check("flush length", 32'(fl_cnt), 32'd64);
    tick;
    tick;
    check("flush absorbed", flush_busy[0], 1'b0);
    miss_fill(0, 32'h2004, 0, 32'hC0, 3, 1'b0, -1, -1, "post-flush 0x2004");
    miss_fill(0, 32'h24, 0, 32'h50, 3, 1'b0, -1, -1, "post-flush 0x24");
    miss_fill(0, 32'h0, 0, 32'hA0, 3, 1'b0, -1, -1, "post-flush 0x0");
    hit_read(0, 32'h0, 32'hA0, "cached 0x0");

    // Reset on refill beat 2: outputs clear, stray beat ignored, old line gone
    cpu_addr[0] = 32'h30;
    cpu_req[0]  = 1'b1;
    tick;
    cpu_req[0]   = 1'b0;
    mem_ready[0] = 1'b1;
    tick;
    mem_ready[0] = 1'b0;
    for (int n = 0; n < 3; n++) begin
      mem_valid[0] = 1'b1;
      mem_data[0]  = 32'h60 + 32'(n);
      rst[0]       = (n == 2);
      tick;
    end
    rst[0]       = 1'b0;
    mem_valid[0] = 1'b0;
    check_zero(0, "mid-fill reset");
    mem_valid[0] = 1'b1;
    mem_data[0]  = 32'h63;
    mem_last[0]  = 1'b1;
    tick;
    mem_valid[0] = 1'b0;
    mem_last[0]  = 1'b0;
    check("stray beat ignored", {29'd0, cpu_valid[0], cpu_stall[0], mem_req[0]}, 32'd0);
    miss_fill(0, 32'h0, 0, 32'hA0, 3, 1'b0, -1, -1, "after reset 0x0");

    // LRU: after hitting 0x0000 the oldest way holds 0x1000
    miss_fill(1, 32'h0, 1, 32'hA0, 3, 1'b0, -1, -1, "lru 0x0");
    miss_fill(1, 32'h1000, 0, 32'hB0, 3, 1'b0, 2, -1, "lru 0x1000");
    miss_fill(1, 32'h2000, 0, 32'hC0, 3, 1'b0, -1, -1, "lru 0x2000");
    miss_fill(1, 32'h3000, 0, 32'hD0, 3, 1'b0, -1, -1, "lru 0x3000");
    hit_read(1, 32'h0, 32'hA0, "lru hit 0x0");
    miss_fill(1, 32'h4000, 0, 32'hE0, 3, 1'b1, -1, -1, "lru 0x4000");
    hit_read(1, 32'h0, 32'hA0, "lru rehit 0x0");
    hit_read(1, 32'h2000, 32'hC0, "lru hit 0x2000");
    miss_fill(1, 32'h1000, 0, 32'hB0, 3, 1'b1, -1, -1, "lru 0x1000 again");
    miss_fill(1, 32'h3000, 0, 32'hD0, 3, 1'b1, -1, -1, "lru 0x3000 evicted");
    hit_read(1, 32'h4, 32'hA1, "lru keep 0x4");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
